// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the Frogger session sequencer: state encodings,
// default timing constants and the life-count thermometer helper.
package game_flow_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_HIT     = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  localparam int DEF_LIVES_INI   = 3;
  localparam int DEF_TICK_DIV    = 1250000;
  localparam int DEF_READY_TICKS = 20;
  localparam int DEF_HIT_TICKS   = 10;
  localparam int DEF_OVER_TICKS  = 40;
  localparam int DEF_GRACE_TICKS = 20;
  localparam int DEF_MAX_LEVEL   = 9;

  // Tick counter width; covers the longest state (game-over hold).
  localparam int TICK_W = 8;

  // Thermometer code with n low bits set (n = 0..3).
  function automatic logic [2:0] lives_therm(input int n);
    logic [2:0] t;
    for (int i = 0; i < 3; i++) begin
      t[i] = (i < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/game_flow_controller_tick_timer.sv
// State timer: a C_TICK_DIV down-counting divider feeding a down-counting
// tick counter. i_Clear reloads both; i_Load is the tick count minus one.
// o_Tick marks the last clock of every tick, o_Done the last clock of the
// final tick, so a load of N-1 expires after exactly N*C_TICK_DIV clocks.
module game_flow_controller_tick_timer
  import game_flow_controller_pkg::*;
#(
  parameter int C_TICK_DIV = DEF_TICK_DIV
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Clear,
  input  logic [TICK_W-1:0] i_Load,
  output logic              o_Tick,
  output logic              o_Done
);

  localparam int DIV_W = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_TICK_DIV - 1);

  logic [DIV_W-1:0]  div_q;
  logic [TICK_W-1:0] tick_q;

  // Divider and tick counter; the tick counter parks at zero once expired.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      div_q  <= '0;
      tick_q <= '0;
    end else if (i_Clear) begin
      div_q  <= DIV_LAST;
      tick_q <= i_Load;
    end else if (div_q == '0) begin
      div_q <= DIV_LAST;
      if (tick_q != '0) tick_q <= tick_q - 1'b1;
    end else begin
      div_q <= div_q - 1'b1;
    end
  end

  assign o_Tick = (div_q == '0);
  assign o_Done = (div_q == '0) && (tick_q == '0);

endmodule

// File: rtl/game_flow_controller.sv
// Frogger session sequencer: start / get-ready / running / hit / game-over.
// Owns lives, level, freeze, respawn and blink controls.
// Optional build macro GAME_GRACE_EN adds a post-respawn grace window in
// which collisions are ignored and the frog blinks.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for an armed start request
// ST_READY   | get-ready countdown, world frozen
// ST_RUNNING | play; collisions cost lives, level-ups advance level
// ST_HIT     | hit freeze with blinking frog, then respawn
// ST_OVER    | game-over hold, start disarmed until released in IDLE
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int C_LIVES_INI   = DEF_LIVES_INI,
  parameter int C_TICK_DIV    = DEF_TICK_DIV,
  parameter int C_READY_TICKS = DEF_READY_TICKS,
  parameter int C_HIT_TICKS   = DEF_HIT_TICKS,
  parameter int C_OVER_TICKS  = DEF_OVER_TICKS,
  parameter int C_GRACE_TICKS = DEF_GRACE_TICKS,
  parameter int C_MAX_LEVEL   = DEF_MAX_LEVEL
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Collision,
  input  logic       i_Level_Up,
  output logic       o_Game_Active,
  output logic       o_Freeze,
  output logic       o_Respawn,
  output logic [2:0] o_Lives,
  output logic [3:0] o_Level,
  output logic       o_Game_Over,
  output logic       o_Blink
);

  localparam logic [3:0] MAX_LEVEL = 4'(C_MAX_LEVEL);

  state_t            state_q, state_d;
  logic              tmr_clear, tmr_tick, tmr_done;
  logic [TICK_W-1:0] tmr_load;

  logic       coll_prev_q, coll_edge_q, lvl_up_q;
  logic       hit_accept, start_go, respawn_go;
  logic [2:0] lives_q;
  logic [3:0] level_q;
  logic       respawn_q, blink_q, armed_q;
  logic       grace_active, grace_tick;

  // Collision edge and level-up are both registered, so they act together
  // one clock after sampling and a simultaneous pair resolves collision-first.
  assign hit_accept = (state_q == ST_RUNNING) && coll_edge_q && !grace_active;
  assign start_go   = (state_q == ST_IDLE) && (state_d == ST_READY);
  assign respawn_go = (state_q == ST_HIT) && (state_d == ST_RUNNING);

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and state-timer reload on every transition.
  always_comb begin
    state_d  = state_q;
    tmr_load = '0;
    unique case (state_q)
      ST_IDLE:    if (i_Start && armed_q) state_d = ST_READY;
      ST_READY:   if (tmr_done) state_d = ST_RUNNING;
      ST_RUNNING: if (hit_accept) state_d = ((lives_q >> 1) == 3'b000) ? ST_OVER : ST_HIT;
      ST_HIT:     if (tmr_done) state_d = ST_RUNNING;
      ST_OVER:    if (tmr_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    tmr_clear = (state_d != state_q);
    case (state_d)
      ST_READY: tmr_load = TICK_W'(C_READY_TICKS - 1);
      ST_HIT:   tmr_load = TICK_W'(C_HIT_TICKS - 1);
      ST_OVER:  tmr_load = TICK_W'(C_OVER_TICKS - 1);
      default:  tmr_load = '0;
    endcase
  end

  game_flow_controller_tick_timer #(
    .C_TICK_DIV (C_TICK_DIV)
  ) u_state_timer (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Clear (tmr_clear),
    .i_Load  (tmr_load),
    .o_Tick  (tmr_tick),
    .o_Done  (tmr_done)
  );

`ifdef GAME_GRACE_EN
  logic grace_q, grace_done;

  game_flow_controller_tick_timer #(
    .C_TICK_DIV (C_TICK_DIV)
  ) u_grace_timer (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Clear (respawn_go),
    .i_Load  (TICK_W'(C_GRACE_TICKS - 1)),
    .o_Tick  (grace_tick),
    .o_Done  (grace_done)
  );

  // Grace window opens at respawn and closes when its timer expires.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)                                grace_q <= 1'b0;
    else if (respawn_go)                         grace_q <= 1'b1;
    else if (state_q != ST_RUNNING || grace_done) grace_q <= 1'b0;
  end

  assign grace_active = grace_q;
`else
  assign grace_active = 1'b0;
  assign grace_tick   = 1'b0;
`endif

  // Input edge capture, lives/level bookkeeping, respawn pulse and start arming.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      coll_prev_q <= 1'b0;
      coll_edge_q <= 1'b0;
      lvl_up_q    <= 1'b0;
      lives_q     <= 3'b000;
      level_q     <= 4'd0;
      respawn_q   <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      coll_prev_q <= i_Collision;
      coll_edge_q <= i_Collision & ~coll_prev_q;
      lvl_up_q    <= i_Level_Up;
      respawn_q   <= start_go || respawn_go;
      if (start_go) begin
        lives_q <= lives_therm(C_LIVES_INI);
        level_q <= 4'd0;
      end else if (hit_accept) begin
        lives_q <= lives_q >> 1;
      end else if (state_q == ST_RUNNING && lvl_up_q && level_q < MAX_LEVEL) begin
        level_q <= level_q + 4'd1;
      end
      if (state_q == ST_OVER)                 armed_q <= 1'b0;
      else if (state_q == ST_IDLE && !i_Start) armed_q <= 1'b1;
    end
  end

  // Blink: starts lit on hit entry, toggles per tick in HIT and grace, else dark.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      blink_q <= 1'b0;
    end else if (state_q != ST_HIT && state_d == ST_HIT) begin
      blink_q <= 1'b1;
    end else if (state_q == ST_HIT && state_d != ST_HIT) begin
      blink_q <= 1'b0;
    end else if (state_q == ST_HIT) begin
      if (tmr_tick) blink_q <= ~blink_q;
    end else if (grace_active) begin
      if (grace_tick) blink_q <= ~blink_q;
    end else begin
      blink_q <= 1'b0;
    end
  end

  assign o_Game_Active = (state_q == ST_RUNNING);
  assign o_Freeze      = (state_q == ST_READY) || (state_q == ST_HIT);
  assign o_Game_Over   = (state_q == ST_OVER);
  assign o_Respawn     = respawn_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Blink       = blink_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a small tick divider.
// Expected values are queued as stimulus is applied and checked in order.
module tb_game_flow_controller;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L, i_Start, i_Collision, i_Level_Up;
  logic       o_Game_Active, o_Freeze, o_Respawn, o_Game_Over, o_Blink;
  logic [2:0] o_Lives;
  logic [3:0] o_Level;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef GAME_GRACE_EN
  localparam bit GRACE = 1'b1;
`else
  localparam bit GRACE = 1'b0;
`endif

  game_flow_controller #(
    .C_LIVES_INI   (3),
    .C_TICK_DIV    (4),
    .C_READY_TICKS (2),
    .C_HIT_TICKS   (2),
    .C_OVER_TICKS  (3),
    .C_GRACE_TICKS (2),
    .C_MAX_LEVEL   (9)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Rst_L       (i_Rst_L),
    .i_Start       (i_Start),
    .i_Collision   (i_Collision),
    .i_Level_Up    (i_Level_Up),
    .o_Game_Active (o_Game_Active),
    .o_Freeze      (o_Freeze),
    .o_Respawn     (o_Respawn),
    .o_Lives       (o_Lives),
    .o_Level       (o_Level),
    .o_Game_Over   (o_Game_Over),
    .o_Blink       (o_Blink)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic expect_val(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wait_active(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_Game_Active === 1'b1) break;
      step(1);
    end
    expect_val(tag, 8'd1);
    chk(8'(o_Game_Active));
  endtask

  task automatic pulse_level(input int n);
    for (int i = 0; i < n; i++) begin
      i_Level_Up = 1'b1;
      step(1);
      i_Level_Up = 1'b0;
      step(1);
    end
  endtask

  initial begin
    i_Rst_L = 1'b0; i_Start = 1'b0; i_Collision = 1'b0; i_Level_Up = 1'b0;
    step(3);
    i_Rst_L = 1'b1;
    step(1);

    // Reset state
    expect_val("rst_lives", 8'd0);  chk(8'(o_Lives));
    expect_val("rst_level", 8'd0);  chk(8'(o_Level));
    expect_val("rst_active", 8'd0); chk(8'(o_Game_Active));
    expect_val("rst_freeze", 8'd0); chk(8'(o_Freeze));
    expect_val("rst_over", 8'd0);   chk(8'(o_Game_Over));
    expect_val("rst_respawn", 8'd0); chk(8'(o_Respawn));

    // Start: lives loaded, one respawn pulse, 8 cycles of freeze
    i_Start = 1'b1;
    expect_val("start_lives", 8'd7);
    expect_val("start_respawn", 8'd1);
    expect_val("start_freeze", 8'd1);
    step(1);
    chk(8'(o_Lives)); chk(8'(o_Respawn)); chk(8'(o_Freeze));
    i_Start = 1'b0;
    expect_val("respawn_one_cycle", 8'd0);
    step(1);
    chk(8'(o_Respawn));
    expect_val("ready_freeze_last", 8'd1);
    expect_val("ready_not_active", 8'd0);
    step(6);
    chk(8'(o_Freeze)); chk(8'(o_Game_Active));
    expect_val("run_active", 8'd1);
    expect_val("run_unfrozen", 8'd0);
    step(1);
    chk(8'(o_Game_Active)); chk(8'(o_Freeze));

    // Two level-ups, then collision and level-up together at level 2
    expect_val("level_two", 8'd2);
    pulse_level(2);
    chk(8'(o_Level));
    i_Collision = 1'b1; i_Level_Up = 1'b1;
    expect_val("simul_lives", 8'd3);
    expect_val("simul_level", 8'd2);
    expect_val("simul_freeze", 8'd1);
    expect_val("simul_not_active", 8'd0);
    step(1);
    i_Level_Up = 1'b0;
    step(1);
    chk(8'(o_Lives)); chk(8'(o_Level)); chk(8'(o_Freeze)); chk(8'(o_Game_Active));
    i_Collision = 1'b0;
    expect_val("hit_freeze_last", 8'd1);
    step(7);
    chk(8'(o_Freeze));
    expect_val("hit_respawn", 8'd1);
    expect_val("hit_back_active", 8'd1);
    expect_val("hit_blink_clear", 8'd0);
    step(1);
    chk(8'(o_Respawn)); chk(8'(o_Game_Active)); chk(8'(o_Blink));

    // Collision edge right after respawn: ignored only with grace
    i_Collision = 1'b1;
    step(1);
    i_Collision = 1'b0;
    expect_val("post_respawn_lives", GRACE ? 8'd3 : 8'd1);
    expect_val("post_respawn_freeze", GRACE ? 8'd0 : 8'd1);
    step(2);
    chk(8'(o_Lives)); chk(8'(o_Freeze));
    if (GRACE) begin
      step(6);
      i_Collision = 1'b1;
      step(1);
      i_Collision = 1'b0;
      expect_val("after_grace_lives", 8'd1);
      step(2);
      chk(8'(o_Lives));
    end
    wait_active("back_to_run", 40);
    step(10);

    // Last life: game over for 12 cycles, start held high must not restart
    i_Collision = 1'b1; i_Start = 1'b1;
    step(1);
    i_Collision = 1'b0;
    expect_val("over_flag", 8'd1);
    expect_val("over_lives", 8'd0);
    step(1);
    chk(8'(o_Game_Over)); chk(8'(o_Lives));
    expect_val("over_last_cycle", 8'd1);
    step(11);
    chk(8'(o_Game_Over));
    expect_val("over_ends", 8'd0);
    step(1);
    chk(8'(o_Game_Over));
    expect_val("disarmed_freeze", 8'd0);
    expect_val("disarmed_lives", 8'd0);
    step(5);
    chk(8'(o_Freeze)); chk(8'(o_Lives));

    // Release and press again: new session, level cleared
    i_Start = 1'b0;
    step(1);
    i_Start = 1'b1;
    expect_val("restart_freeze", 8'd1);
    expect_val("restart_respawn", 8'd1);
    expect_val("restart_lives", 8'd7);
    expect_val("restart_level", 8'd0);
    step(1);
    chk(8'(o_Freeze)); chk(8'(o_Respawn)); chk(8'(o_Lives)); chk(8'(o_Level));
    i_Start = 1'b0;

    // Collision held high across entry to RUNNING is not counted
    i_Collision = 1'b1;
    wait_active("restart_run", 20);
    expect_val("held_coll_lives", 8'd7);
    step(3);
    chk(8'(o_Lives));
    i_Collision = 1'b0;
    step(2);

    // Level saturation
    expect_val("level_three", 8'd3);
    pulse_level(3);
    chk(8'(o_Level));
    expect_val("level_sat", 8'd9);
    pulse_level(7);
    chk(8'(o_Level));
    expect_val("level_sat_hold", 8'd9);
    pulse_level(1);
    chk(8'(o_Level));

    // Reset during HIT
    i_Collision = 1'b1;
    step(1);
    i_Collision = 1'b0;
    expect_val("hit2_freeze", 8'd1);
    expect_val("hit2_lives", 8'd3);
    step(1);
    chk(8'(o_Freeze)); chk(8'(o_Lives));
    step(2);
    i_Rst_L = 1'b0;
    #1;
    expect_val("async_rst_freeze", 8'd0);
    expect_val("async_rst_lives", 8'd0);
    expect_val("async_rst_active", 8'd0);
    chk(8'(o_Freeze)); chk(8'(o_Lives)); chk(8'(o_Game_Active));
    step(1);
    i_Rst_L = 1'b1;
    expect_val("release_respawn", 8'd0);
    step(1);
    chk(8'(o_Respawn));
    expect_val("release_respawn_later", 8'd0);
    expect_val("release_freeze", 8'd0);
    step(3);
    chk(8'(o_Respawn)); chk(8'(o_Freeze));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
